// File: rtl/id_ex_if.sv
// Bundle of the decode-to-execute signals exchanged with id_ex_stage.
// The master (decode/hazard side) drives the id_* fields, MEM feedback and control; the slave is the EX register.
interface id_ex_if;
  logic        id_valid;
  logic [31:0] id_A;
  logic [31:0] id_B;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [3:0]  id_ALUop;
  logic        id_ALUsrc;
  logic        id_regwrite;
  logic        id_memread;
  logic [4:0]  mem_rd;
  logic        mem_regwrite;
  logic        flush;
  logic        ex_hold;

  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] immediate;
  logic [1:0]  SEL_A;
  logic [1:0]  SEL_B;
  logic [3:0]  ALUop;
  logic        ALUsrc;
  logic        regwrite;
  logic        memread;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        stall;
  logic [15:0] bubble_cnt;

  modport master (
    output id_valid, id_A, id_B, id_imm, id_rs1, id_rs2, id_rd,
           id_ALUop, id_ALUsrc, id_regwrite, id_memread,
           mem_rd, mem_regwrite, flush, ex_hold,
    input  A, B, immediate, SEL_A, SEL_B, ALUop, ALUsrc, regwrite,
           memread, ex_valid, ex_rd, stall, bubble_cnt
  );

  modport slave (
    input  id_valid, id_A, id_B, id_imm, id_rs1, id_rs2, id_rd,
           id_ALUop, id_ALUsrc, id_regwrite, id_memread,
           mem_rd, mem_regwrite, flush, ex_hold,
    output A, B, immediate, SEL_A, SEL_B, ALUop, ALUsrc, regwrite,
           memread, ex_valid, ex_rd, stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use/RAW hazard detection, forwarding selects and a saturating bubble counter.
// Define ID_EX_FWD_EN to enable operand forwarding; without it every RAW dependency on EX or MEM stalls.
module id_ex_stage (
  input logic  clk,
  input logic  rst_n,
  id_ex_if.slave bus
);

  logic        ex_valid_q;
  logic        regwrite_q;
  logic        memread_q;
  logic        alusrc_q;
  logic [3:0]  alu_op_q;
  logic [1:0]  sel_a_q;
  logic [1:0]  sel_b_q;
  logic [4:0]  ex_rd_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] imm_q;
  logic [15:0] bubble_cnt_q;

  logic        load_use;
  logic        hazard;
  logic [1:0]  sel_a_d;
  logic [1:0]  sel_b_d;

`ifdef ID_EX_FWD_EN
  // EX is the newer producer, so it is checked before MEM; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (ex_valid_q && regwrite_q && (ex_rd_q != 5'd0) && (ex_rd_q == rs))
      return 2'd2;
    else if (bus.mem_regwrite && (bus.mem_rd != 5'd0) && (bus.mem_rd == rs))
      return 2'd1;
    else
      return 2'd0;
  endfunction
`endif

  always_comb begin
    load_use = ex_valid_q && memread_q && (ex_rd_q != 5'd0) && bus.id_valid &&
               ((ex_rd_q == bus.id_rs1) || ((ex_rd_q == bus.id_rs2) && !bus.id_ALUsrc));
`ifdef ID_EX_FWD_EN
    sel_a_d = fwd_sel(bus.id_rs1);
    sel_b_d = fwd_sel(bus.id_rs2);
    hazard  = load_use;
`else
    sel_a_d = 2'd0;
    sel_b_d = 2'd0;
    hazard  = load_use ||
              (bus.id_valid && ex_valid_q && regwrite_q && (ex_rd_q != 5'd0) &&
               ((ex_rd_q == bus.id_rs1) || (ex_rd_q == bus.id_rs2))) ||
              (bus.id_valid && bus.mem_regwrite && (bus.mem_rd != 5'd0) &&
               ((bus.mem_rd == bus.id_rs1) || (bus.mem_rd == bus.id_rs2)));
`endif
  end

  // Reset must release decode immediately, and a flush overrides any stall reason.
  assign bus.stall = rst_n && !bus.flush && (bus.ex_hold || hazard);

  // Priority: flush, then hold, then hazard bubble, then capture; bubbles leave data fields untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      alusrc_q     <= 1'b0;
      alu_op_q     <= 4'd0;
      sel_a_q      <= 2'd0;
      sel_b_q      <= 2'd0;
      ex_rd_q      <= 5'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      imm_q        <= 32'd0;
      bubble_cnt_q <= 16'd0;
    end else if (bus.flush || (!bus.ex_hold && (hazard || !bus.id_valid))) begin
      ex_valid_q <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      alu_op_q   <= 4'd0;
      sel_a_q    <= 2'd0;
      sel_b_q    <= 2'd0;
      ex_rd_q    <= 5'd0;
      if (!bus.flush && hazard && (bubble_cnt_q != 16'hFFFF))
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end else if (!bus.ex_hold) begin
      ex_valid_q <= 1'b1;
      regwrite_q <= bus.id_regwrite;
      memread_q  <= bus.id_memread;
      alusrc_q   <= bus.id_ALUsrc;
      alu_op_q   <= bus.id_ALUop;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      ex_rd_q    <= bus.id_rd;
      a_q        <= bus.id_A;
      b_q        <= bus.id_B;
      imm_q      <= bus.id_imm;
    end
  end

  assign bus.ex_valid   = ex_valid_q;
  assign bus.regwrite   = regwrite_q;
  assign bus.memread    = memread_q;
  assign bus.ALUsrc     = alusrc_q;
  assign bus.ALUop      = alu_op_q;
  assign bus.SEL_A      = sel_a_q;
  assign bus.SEL_B      = sel_b_q;
  assign bus.ex_rd      = ex_rd_q;
  assign bus.A          = a_q;
  assign bus.B          = b_q;
  assign bus.immediate  = imm_q;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; all ports listed below.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 id_valid  in  1  decode holds a valid instruction.
REQ-005 id_A, id_B, id_imm  in  32 each  register-file operands, sign-extended immediate.
REQ-006 id_rs1, id_rs2, id_rd  in  5 each  source/destination register indices.
REQ-007 id_ALUop  in  4; id_ALUsrc, id_regwrite, id_memread  in  1 each  decoded controls.
REQ-008 mem_rd  in  5; mem_regwrite  in  1  destination of instruction currently in MEM.
REQ-009 flush  in  1  squash EX contents (branch redirect); ex_hold  in  1  downstream freeze.
REQ-010 A, B, immediate  out  32 each  registered operands to ALU_top.
REQ-011 SEL_A, SEL_B  out  2 each  registered forwarding selects: 0 = register file, 1 = WB value, 2 = ALU (EX/MEM) value; 3 never driven.
REQ-012 ALUop out 4; ALUsrc, regwrite, memread, ex_valid  out 1 each; ex_rd out 5.
REQ-013 stall  out  1  combinational: decode and fetch SHALL hold this cycle.
REQ-014 bubble_cnt  out  16  count of inserted bubbles.

Function
REQ-015 Per-edge priority SHALL be: flush > ex_hold > hazard bubble > capture.
REQ-016 flush: next edge clears ex_valid, regwrite, memread, ALUop=0, SEL_A=SEL_B=0; data outputs don't-care.
REQ-017 ex_hold (no flush): all outputs retain values; stall=1.
REQ-018 Load-use hazard = ex_valid & memread & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | (ex_rd==id_rs2 & !id_ALUsrc)).
REQ-019 Hazard: stall=1; next edge loads bubble (as REQ-016) and increments bubble_cnt.
REQ-020 Capture (id_valid, no stall): all id_* fields registered to outputs, 1-cycle latency; !id_valid loads a bubble without counting it.
REQ-021 SEL_A computed at capture: 2 if ex_valid & regwrite & ex_rd!=0 & ex_rd==id_rs1; else 1 if mem_regwrite & mem_rd!=0 & mem_rd==id_rs1; else 0. SEL_B identical on id_rs2.
REQ-022 Newer producer (EX) SHALL win when both EX and MEM match.
REQ-023 Register index 0 SHALL never be forwarded or cause a stall.
REQ-024 bubble_cnt SHALL saturate at 16'hFFFF, not wrap.
REQ-025 Flush with a simultaneous hazard SHALL still produce stall=0 and a flush bubble (uncounted).

Reset
REQ-026 While rst_n=0: all outputs 0, including ex_valid, SEL_A, SEL_B, bubble_cnt, ex_rd.
REQ-027 Reset assertion mid-stall SHALL immediately drop stall to 0; first edge after release captures normally.

Configuration
REQ-028 Macro ID_EX_FWD_EN defined: forwarding per REQ-021/022; stalls only per REQ-018.
REQ-029 Macro undefined: SEL_A=SEL_B=0 always; hazard extends to any RAW match (rd!=0) against EX-held instruction (regwrite) or MEM (mem_regwrite), each stalling and counting.

Verification
REQ-030 Capture: id_A=10, id_B=5, ALUop=4'b0010, no hazards -> next cycle A=10, B=5, ALUop=2, SEL_A=SEL_B=0, ex_valid=1.
REQ-031 EX forward: EX holds rd=3 regwrite; id_rs1=3 -> SEL_A=2; also mem_rd=3 -> still SEL_A=2; EX rd=0 -> SEL_A=0 (FWD_EN).
REQ-032 Load-use: EX memread rd=5, id_rs2=5, ALUsrc=0 -> stall=1, bubble, bubble_cnt=1; with ALUsrc=1 -> no stall.
REQ-033 Flush + hazard same cycle -> stall=0, ex_valid=0 next cycle, bubble_cnt unchanged; ex_hold=1 -> outputs frozen 3 cycles.
REQ-034 Reset asserted during stall -> outputs 0 asynchronously; bubble_cnt forced to 16'hFFFF precondition + hazard -> stays 16'hFFFF.
REQ-035 Without ID_EX_FWD_EN: mem_rd=7 mem_regwrite, id_rs1=7 -> stall=1, SEL_A=0.
